// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between a data-side port (0)
// and an instruction-side port (1); the winning command is latched for the whole access.
//
// state  | meaning
// IDLE   | no access in flight, SRAM enables low, arbitrating pending requests
// GRANT0 | port 0 command latched and driven to the SRAM until sram_ready
// GRANT1 | port 1 command latched and driven to the SRAM until sram_ready
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_read_en,
  input  logic               p0_write_en,
  input  logic [ADDR_W-1:0]  p0_address,
  input  logic [WDATA_W-1:0] p0_write_data,
  output logic [RDATA_W-1:0] p0_read_data,
  output logic               p0_ready,
  input  logic               p1_read_en,
  input  logic               p1_write_en,
  input  logic [ADDR_W-1:0]  p1_address,
  input  logic [WDATA_W-1:0] p1_write_data,
  output logic [RDATA_W-1:0] p1_read_data,
  output logic               p1_ready,
  output logic               sram_read_en,
  output logic               sram_write_en,
  output logic [ADDR_W-1:0]  sram_address,
  output logic [WDATA_W-1:0] sram_write_data,
  input  logic [RDATA_W-1:0] sram_read_data,
  input  logic               sram_ready
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 cmd_is_write_q, cmd_is_write_d;
  logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
  logic [WDATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [RDATA_W-1:0]   hold0_q, hold0_d;
  logic [RDATA_W-1:0]   hold1_q, hold1_d;

  logic req0, req1, grant0, grant1;

  assign req0   = p0_read_en | p0_write_en;
  assign req1   = p1_read_en | p1_write_en;
  assign grant0 = (state_q == GRANT0);
  assign grant1 = (state_q == GRANT1);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cmd_is_write_d = cmd_is_write_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_wdata_d    = cmd_wdata_q;
    hold0_d        = hold0_q;
    hold1_d        = hold1_q;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time is served.
        if (req0 && (!req1 || last_grant_q)) begin
          state_d        = GRANT0;
          last_grant_d   = 1'b0;
          cmd_is_write_d = p0_write_en;
          cmd_addr_d     = p0_address;
          cmd_wdata_d    = p0_write_data;
        end else if (req1) begin
          state_d        = GRANT1;
          last_grant_d   = 1'b1;
          cmd_is_write_d = p1_write_en;
          cmd_addr_d     = p1_address;
          cmd_wdata_d    = p1_write_data;
        end
      end
      GRANT0: begin
        if (sram_ready) begin
          state_d = IDLE;
          if (!cmd_is_write_q) hold0_d = sram_read_data;
        end
      end
      GRANT1: begin
        if (sram_ready) begin
          state_d = IDLE;
          if (!cmd_is_write_q) hold1_d = sram_read_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      cmd_is_write_q <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
      hold0_q        <= '0;
      hold1_q        <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cmd_is_write_q <= cmd_is_write_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_wdata_q    <= cmd_wdata_d;
      hold0_q        <= hold0_d;
      hold1_q        <= hold1_d;
    end
  end

  // Enables decode straight from state so an async reset drops them at once.
  assign sram_write_en   = (grant0 | grant1) & cmd_is_write_q;
  assign sram_read_en    = (grant0 | grant1) & ~cmd_is_write_q;
  assign sram_address    = cmd_addr_q;
  assign sram_write_data = cmd_wdata_q;

  assign p0_ready     = ~req0 | (grant0 & sram_ready);
  assign p1_ready     = ~req1 | (grant1 & sram_ready);
  assign p0_read_data = (grant0 & sram_ready) ? sram_read_data : hold0_q;
  assign p1_read_data = (grant1 & sram_ready) ? sram_read_data : hold1_q;

endmodule
